// File: rtl/a2d_scan_intf_if.sv
// Host scan controls, result read port and SPI link to the ADC, bundled.
// master: host / ADC environment side; slave: the scan engine.
interface a2d_scan_intf_if #(
  parameter int NUM_CHNL = 8,
  parameter int RES_W    = 12
);
  logic                strt_scan;
  logic [NUM_CHNL-1:0] chnl_mask;
  logic [2:0]          rd_chnl;
  logic [RES_W-1:0]    rd_res;
  logic                busy;
  logic                scan_cmplt;
  logic                SS_n;
  logic                SCLK;
  logic                MOSI;
  logic                MISO;

  modport master (
    output strt_scan, chnl_mask, rd_chnl, MISO,
    input  rd_res, busy, scan_cmplt, SS_n, SCLK, MOSI
  );

  modport slave (
    input  strt_scan, chnl_mask, rd_chnl, MISO,
    output rd_res, busy, scan_cmplt, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/a2d_scan_intf.sv
// a2d_scan_intf: converts every channel set in a latched mask over an SPI
// ADC link (one discarded frame, then the result frame) and keeps one
// inverted result per channel in a combinationally read result file.
// Build macro A2D_AVG_EN: four result frames per channel, averaged.
//
// state | meaning
// IDLE  | waiting for strt_scan
// SEL   | pick lowest pending channel, or finish
// FRM1  | command frame, read data discarded
// GAP   | SS_n high for 2 clk between frames
// FRM2  | command frame, read data is the sample
// STORE | write result to the channel slot
// DONE  | raise scan_cmplt, drop busy
module a2d_scan_intf #(
  parameter int NUM_CHNL = 8,
  parameter int RES_W    = 12,
  parameter int SCLK_DIV = 32
) (
  input logic            clk,
  input logic            rst_n,
  a2d_scan_intf_if.slave bus
);
  localparam int HALF  = SCLK_DIV / 2;
  localparam int CNT_W = $clog2(HALF + 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, SEL, FRM1, GAP, FRM2, STORE, DONE} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                cmplt_q, cmplt_d;
  logic                ss_n_q, ss_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CHNL-1:0] pend_q, pend_d;
  logic [2:0]          chnl_q, chnl_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [5:0]          seg_q, seg_d;
  logic [15:0]         tx_q, tx_d;
  logic [RES_W-1:0]    rx_q, rx_d;
  logic [RES_W-1:0]    res_q [NUM_CHNL];
  logic [RES_W-1:0]    res_d [NUM_CHNL];
  logic [2:0]          sel_idx;
  logic                frm_end;
  logic [RES_W-1:0]    store_val;
  logic [RES_W-1:0]    rd_res_c;
`ifdef A2D_AVG_EN
  logic [RES_W+1:0]    acc_q, acc_d;
  logic [1:0]          rep_q, rep_d;

  assign store_val = acc_q[RES_W+1:2];
`else
  assign store_val = ~rx_q;
`endif

  // Lowest pending channel in the latched mask.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CHNL - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = 3'(i);
    end
  end

  // Next-state logic: scan sequencing plus the shared SPI frame engine.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cmplt_d = cmplt_q;
    ss_n_d  = ss_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    pend_d  = pend_q;
    chnl_d  = chnl_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    res_d   = res_q;
    frm_end = 1'b0;
`ifdef A2D_AVG_EN
    acc_d   = acc_q;
    rep_d   = rep_q;
`endif

    // A frame is 33 half-periods: lead-in, 16 low/high SCLK pairs; the last
    // high half doubles as the SS_n trailing time.
    if (state_q == FRM1 || state_q == FRM2) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d = HALF_LD;
        if (seg_q == 6'd32) begin
          frm_end = 1'b1;
          ss_n_d  = 1'b1;
          mosi_d  = 1'b0;
        end else begin
          seg_d = seg_q + 6'd1;
          if (!seg_q[0]) begin
            sclk_d = 1'b0;
            mosi_d = tx_q[15];
            tx_d   = {tx_q[14:0], 1'b0};
          end else begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[RES_W-2:0], bus.MISO};
          end
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.strt_scan) begin
          pend_d  = bus.chnl_mask;
          cmplt_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SEL;
        end
      end
      SEL: begin
        if (pend_q != '0) begin
          chnl_d  = sel_idx;
          pend_d  = pend_q & (pend_q - NUM_CHNL'(1));
          ss_n_d  = 1'b0;
          sclk_d  = 1'b1;
          seg_d   = '0;
          cnt_d   = HALF_LD;
          tx_d    = {2'b00, sel_idx, 11'h000};
`ifdef A2D_AVG_EN
          acc_d   = '0;
          rep_d   = '0;
`endif
          state_d = FRM1;
        end else begin
          // Dropping busy here keeps an empty scan to a single busy cycle.
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      FRM1: begin
        if (frm_end) begin
          cnt_d   = GAP_LD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ss_n_d  = 1'b0;
          seg_d   = '0;
          cnt_d   = HALF_LD;
          tx_d    = {2'b00, chnl_q, 11'h000};
          state_d = FRM2;
        end
      end
      FRM2: begin
        if (frm_end) begin
`ifdef A2D_AVG_EN
          acc_d = acc_q + {2'b00, ~rx_q};
          rep_d = rep_q + 2'd1;
          if (rep_q == 2'd3) begin
            state_d = STORE;
          end else begin
            cnt_d   = GAP_LD;
            state_d = GAP;
          end
`else
          state_d = STORE;
`endif
        end
      end
      STORE: begin
        for (int i = 0; i < NUM_CHNL; i++) begin
          if (chnl_q == 3'(i)) res_d[i] = store_val;
        end
        state_d = SEL;
      end
      DONE: begin
        cmplt_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame with SS_n high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cmplt_q <= 1'b0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      pend_q  <= '0;
      chnl_q  <= '0;
      cnt_q   <= '0;
      seg_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      res_q   <= '{default: '0};
`ifdef A2D_AVG_EN
      acc_q   <= '0;
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cmplt_q <= cmplt_d;
      ss_n_q  <= ss_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      pend_q  <= pend_d;
      chnl_q  <= chnl_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      res_q   <= res_d;
`ifdef A2D_AVG_EN
      acc_q   <= acc_d;
      rep_q   <= rep_d;
`endif
    end
  end

  // Zero-latency result read; indices past NUM_CHNL read 0.
  always_comb begin
    rd_res_c = '0;
    for (int i = 0; i < NUM_CHNL; i++) begin
      if (bus.rd_chnl == 3'(i)) rd_res_c = res_q[i];
    end
  end

  assign bus.rd_res     = rd_res_c;
  assign bus.busy       = busy_q;
  assign bus.scan_cmplt = cmplt_q;
  assign bus.SS_n       = ss_n_q;
  assign bus.SCLK       = sclk_q;
  assign bus.MOSI       = mosi_q;
endmodule

// File: tb/tb_a2d_scan_intf.sv
// Bench for a2d_scan_intf: ADC model plus frame scoreboard, directed scans.
module tb_a2d_scan_intf;
  localparam int NUM_CHNL = 8;
  localparam int RES_W    = 12;
  localparam int SCLK_DIV = 32;
  localparam int HALF     = SCLK_DIV / 2;
`ifdef A2D_AVG_EN
  localparam int NREP = 4;
`else
  localparam int NREP = 1;
`endif

  typedef struct packed {
    logic [15:0] cmd;
    logic        gap_chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int unsigned cyc = 0;

  exp_t        exp_q[$];
  logic [15:0] adc_q[$];
  logic [15:0] adc_word = 16'h0000;
  logic [11:0] model [NUM_CHNL];
  logic [15:0] avg_words [4];

  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b1;
  bit          in_frm = 1'b0;
  int          nrise = 0;
  int          nfall = 0;
  int          frame_cnt = 0;
  int unsigned ss_fall_cyc = 0;
  int unsigned ss_rise_cyc = 0;
  int unsigned rise_cyc = 0;
  logic [15:0] mosi_w = '0;
  logic [15:0] miso_w = '0;
  exp_t        e;

  a2d_scan_intf_if #(.NUM_CHNL(NUM_CHNL), .RES_W(RES_W)) bus ();

  a2d_scan_intf #(.NUM_CHNL(NUM_CHNL), .RES_W(RES_W), .SCLK_DIV(SCLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ADC model and frame monitor: serves MISO, captures MOSI, checks timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ss   = 1'b1;
      prev_sclk = 1'b1;
      in_frm    = 1'b0;
      nrise     = 0;
      nfall     = 0;
      bus.MISO  = 1'b0;
    end else begin
      if (prev_ss && !bus.SS_n) begin
        in_frm      = 1'b1;
        nrise       = 0;
        nfall       = 0;
        mosi_w      = '0;
        ss_fall_cyc = cyc;
        if (adc_q.size() > 0) miso_w = adc_q.pop_front();
        else miso_w = adc_word;
        if (exp_q.size() > 0 && exp_q[0].gap_chk) chk("ss_gap", cyc - ss_rise_cyc, 2);
      end
      if (in_frm && prev_sclk && !bus.SCLK) begin
        if (nfall == 0) chk("ss_lead", cyc - ss_fall_cyc, HALF);
        if (nfall < 16) bus.MISO = miso_w[15 - nfall];
        nfall++;
      end
      if (in_frm && !prev_sclk && bus.SCLK) begin
        mosi_w   = {mosi_w[14:0], bus.MOSI};
        nrise++;
        rise_cyc = cyc;
      end
      if (in_frm && !prev_ss && bus.SS_n) begin
        in_frm      = 1'b0;
        frame_cnt++;
        ss_rise_cyc = cyc;
        chk("sclk_count", nrise, 16);
        chk("ss_tail", cyc - rise_cyc, HALF);
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL frame_cmd: unexpected frame got %h expected none", mosi_w);
        end else begin
          e = exp_q.pop_front();
          if (mosi_w === e.cmd) n_pass++;
          else $display("FAIL frame_cmd: got %h expected %h", mosi_w, e.cmd);
        end
      end
      prev_ss   = bus.SS_n;
      prev_sclk = bus.SCLK;
    end
  end

  task automatic push_chan(input logic [2:0] ch);
    exp_q.push_back('{cmd: {2'b00, ch, 11'h000}, gap_chk: 1'b0});
    for (int k = 0; k < NREP; k++) exp_q.push_back('{cmd: {2'b00, ch, 11'h000}, gap_chk: 1'b1});
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NUM_CHNL; c++) begin
      @(negedge clk);
      bus.rd_chnl = 3'(c);
      #1;
      chk($sformatf("%s_rd_res_ch%0d", tag, c), bus.rd_res, model[c]);
    end
  endtask

  task automatic start(input logic [7:0] mask);
    @(negedge clk);
    bus.strt_scan = 1'b1;
    bus.chnl_mask = mask;
    @(negedge clk);
    bus.strt_scan = 1'b0;
    chk("busy_set", bus.busy, 1);
    chk("cmplt_clr", bus.scan_cmplt, 0);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (bus.scan_cmplt) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s_done: got scan_cmplt=0 after 15000 cycles expected 1", tag);
    chk({tag, "_busy_clr"}, bus.busy, 0);
  endtask

  task automatic run_scan(input string tag, input logic [7:0] mask, input logic [15:0] word,
                          input logic [11:0] exp_res, input bit poke);
    int  base;
    bit  seen = 1'b0;
    adc_word = word;
    for (int c = 0; c < NUM_CHNL; c++) if (mask[c]) push_chan(3'(c));
    base = frame_cnt;
    start(mask);
    if (poke) begin
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (frame_cnt >= base + 1) begin
          seen = 1'b1;
          break;
        end
      end
      n_chk++;
      if (seen) n_pass++;
      else $display("FAIL %s_first_frame: got no frame expected one", tag);
      @(negedge clk);
      bus.strt_scan = 1'b1;
      bus.chnl_mask = 8'h01;
      @(negedge clk);
      bus.strt_scan = 1'b0;
      chk({tag, "_busy_held"}, bus.busy, 1);
    end
    wait_done(tag);
    for (int c = 0; c < NUM_CHNL; c++) if (mask[c]) model[c] = exp_res;
    check_all(tag);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected finish by 80000 cycles");
    $fatal(1);
  end

  initial begin
    int  base;
    bit  hit;
    bus.strt_scan = 1'b0;
    bus.chnl_mask = '0;
    bus.rd_chnl   = '0;
    for (int c = 0; c < NUM_CHNL; c++) model[c] = '0;
    avg_words[0] = 16'h0F9B;   // ~100
    avg_words[1] = 16'h0F9A;   // ~101
    avg_words[2] = 16'h0F99;   // ~102
    avg_words[3] = 16'h0F98;   // ~103

    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cmplt", bus.scan_cmplt, 0);
    chk("rst_ss_n", bus.SS_n, 1);
    chk("rst_sclk", bus.SCLK, 1);
    chk("rst_mosi", bus.MOSI, 0);
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_scan("m01", 8'h01, 16'hF000, 12'hFFF, 1'b0);
    chk("m01_cmplt", bus.scan_cmplt, 1);
    run_scan("m84", 8'h84, 16'h0123, 12'hEDC, 1'b0);

    base = frame_cnt;
    @(negedge clk);
    bus.strt_scan = 1'b1;
    bus.chnl_mask = 8'h00;
    @(negedge clk);
    bus.strt_scan = 1'b0;
    chk("empty_busy_c1", bus.busy, 1);
    chk("empty_cmplt_c1", bus.scan_cmplt, 0);
    @(negedge clk);
    chk("empty_busy_c2", bus.busy, 0);
    chk("empty_cmplt_c2", bus.scan_cmplt, 0);
    @(negedge clk);
    chk("empty_cmplt_c3", bus.scan_cmplt, 1);
    repeat (4) @(negedge clk);
    chk("empty_frames", frame_cnt, base);
    chk("empty_ss_n", bus.SS_n, 1);

    run_scan("poke", 8'h06, 16'h0456, 12'hBA9, 1'b1);

    adc_q.push_back(16'h0000);
    for (int k = 0; k < NREP; k++) adc_q.push_back(avg_words[k]);
    run_scan("avg", 8'h02, 16'h0000, (NREP == 4) ? 12'd101 : 12'd100, 1'b0);

    push_chan(3'd0);
    adc_word = 16'h0123;
    base = frame_cnt;
    start(8'h01);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_cnt == base + 1 && in_frm && nfall == 8) begin
        hit = 1'b1;
        break;
      end
    end
    n_chk++;
    if (hit) n_pass++;
    else $display("FAIL abort_reach: got no 8th SCLK of FRM2 expected one");
    chk("abort_pre_ss_n", bus.SS_n, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_ss_n", bus.SS_n, 1);
    chk("abort_sclk", bus.SCLK, 1);
    chk("abort_busy", bus.busy, 0);
    exp_q.delete();
    adc_q.delete();
    for (int c = 0; c < NUM_CHNL; c++) model[c] = '0;
    check_all("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_scan("post", 8'h08, 16'h0F0F, 12'h0F0, 1'b0);

    repeat (4) @(negedge clk);
    chk("frames_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/a2d_scan_intf.md
A2D_SCAN_INTF -- requirements
Module: a2d_scan_intf

Interface
REQ-001 SHALL have parameter NUM_CHNL, default 8, number of scannable channels (legal 1..8).
REQ-002 SHALL have parameter RES_W, default 12, result width (legal 8..16).
REQ-003 SHALL have parameter SCLK_DIV, default 32, clk cycles per SCLK period (even, >=4).
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port strt_scan  in  1  one-cycle scan request.
REQ-007 SHALL have port chnl_mask  in  NUM_CHNL  channels to convert; bit i = channel i.
REQ-008 SHALL have port rd_chnl  in  3  result-file read index.
REQ-009 SHALL have port rd_res  out  RES_W  stored result of channel rd_chnl.
REQ-010 SHALL have port busy  out  1  high while a scan is in progress.
REQ-011 SHALL have port scan_cmplt  out  1  sticky scan-done flag.
REQ-012 SHALL have ports SS_n out 1, SCLK out 1, MOSI out 1, MISO in 1: SPI master to the ADC.

Function
REQ-013 SHALL accept strt_scan only in IDLE; accepting it latches chnl_mask, clears scan_cmplt, and sets busy on the next cycle.
REQ-014 SHALL ignore strt_scan while busy; the latched mask is not changed mid-scan.
REQ-015 SHALL use states IDLE, SEL, FRM1, GAP, FRM2, STORE, DONE.
REQ-016 SEL SHALL pick the lowest unvisited set mask bit -> FRM1; with none left -> DONE.
REQ-017 FRM1 SHALL send one 16-bit frame with cmd {2'b00, chnl[2:0], 11'h000}; its read data is discarded.
REQ-018 GAP SHALL hold SS_n high for exactly 2 clk cycles, then -> FRM2.
REQ-019 FRM2 SHALL resend the same cmd; the result SHALL be ~rd_data[RES_W-1:0] (bitwise inverted).
REQ-020 STORE SHALL write the result to the channel's slot in one cycle, then -> SEL.
REQ-021 DONE SHALL set scan_cmplt, clear busy, and go to IDLE on the same edge; a new strt_scan is accepted the next cycle.
REQ-022 SPI timing: SCLK idles high; MOSI MSB-first, changing on SCLK fall; MISO sampled on SCLK rise; 16 SCLK periods per frame.
REQ-023 SS_n SHALL fall SCLK_DIV/2 clks before the first SCLK fall and rise SCLK_DIV/2 clks after the 16th SCLK rise.
REQ-024 Empty mask: DONE SHALL be reached with zero SPI frames; scan_cmplt SHALL go high 2 cycles after strt_scan.
REQ-025 Unmasked channels SHALL keep previous results; rd_chnl >= NUM_CHNL SHALL read 0.
REQ-026 rd_res SHALL be combinational from the result file (zero-latency read).

Reset
REQ-027 rst_n low SHALL force IDLE, busy=0, scan_cmplt=0, SS_n=1, SCLK=1, MOSI=0, and all results to 0.
REQ-028 Reset mid-frame SHALL abort immediately (SS_n=1 asynchronously); no partial result is stored.

Configuration
REQ-029 Macro A2D_AVG_EN defined: FRM2 SHALL repeat 4 times per channel, with a 2-clk GAP between repeats; the 4 inverted samples are summed in a RES_W+2 accumulator and the sum>>2 is stored.
REQ-030 A2D_AVG_EN undefined: one FRM2 per channel; the single sample is stored directly; no accumulator is built.

Verification
REQ-031 Mask 8'h01, MISO model returns 16'hF000 -> two frames with MOSI cmd 16'h0000; rd_chnl=0 gives 12'hFFF; scan_cmplt=1.
REQ-032 Mask 8'h84, model returns 16'h0123 -> frames for channel 2 (cmd 16'h1000) then channel 7 (cmd 16'h3800); both slots read 12'hEDC; others keep prior values.
REQ-033 Mask 8'h00 -> no SS_n activity; scan_cmplt high 2 cycles after strt_scan; busy never exceeds 1 cycle.
REQ-034 strt_scan pulsed mid-scan with a different mask -> ignored; original channel order and frame count unchanged.
REQ-035 rst_n asserted during 8th SCLK of FRM2 -> SS_n=1 and SCLK=1 the same cycle; all results read 0; a subsequent scan completes normally.
REQ-036 A2D_AVG_EN, mask 8'h02, inverted samples 100,101,102,103 -> 5 frames total; stored result 101.
